led_pattern_engine: RTL and testbench

//   Parametrised N-LED pattern sequencer: bounce, rotate, fill and blink modes

---
 rtl/led_pattern_engine.sv | 172 +++++++++++++++++
 tb/tb_led_pattern_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// N-LED pattern sequencer (bounce, rotate, fill, blink) with a prescaled step rate
// and a dimmed trail. Single clock domain; all outputs registered.
module led_pattern_engine #(
  parameter int unsigned N       = 8,
  parameter int unsigned CLK_HZ  = 1_000_000,
  parameter int unsigned STEP_HZ = 10,
  parameter int unsigned TRAIL   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [2:0]               speed,
  output logic [N-1:0]             led,
  output logic [$clog2(N+1)-1:0]   pos,
  output logic                     step_pulse
);

  localparam int unsigned DIV    = CLK_HZ / STEP_HZ;
  localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PosW   = $clog2(N + 1);
  localparam int unsigned TrailN = (TRAIL > 0) ? TRAIL : 1;
  localparam bit          TrailEn = (TRAIL > 0);

  localparam logic [1:0] ModeBounce = 2'b00;
  localparam logic [1:0] ModeRotate = 2'b01;
  localparam logic [1:0] ModeFill   = 2'b10;
  localparam logic [1:0] ModeBlink  = 2'b11;

  if (N < 2) begin : g_bad_n
    $error("led_pattern_engine: N must be at least 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("led_pattern_engine: CLK_HZ/STEP_HZ must be at least 2");
  end
  if (TRAIL >= N) begin : g_bad_trail
    $error("led_pattern_engine: TRAIL must be below N");
  end

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      spd_cnt_q, spd_cnt_d;
  logic [1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [1:0]      cur_mode_q, cur_mode_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic            dir_q, dir_d;  // 0 = counting up
  logic [PosW-1:0] trail_q [TrailN];
  logic [PosW-1:0] trail_d [TrailN];
  logic [TrailN-1:0] trail_vld_q, trail_vld_d;
  logic [N-1:0]    led_q, led_d;
  logic            step_q;

  logic base_tick;
  logic step;

  function automatic logic [N-1:0] onehot(input logic [PosW-1:0] p);
    logic [N-1:0] one;
    one = N'(1);
    return one << p;
  endfunction

  // Shifting past the top yields zero, so pos == N wraps to all-on after the subtract.
  function automatic logic [N-1:0] fill_mask(input logic [PosW-1:0] p);
    logic [N-1:0] one;
    one = N'(1);
    return (one << p) - one;
  endfunction

  assign base_tick = en && (div_cnt_q == DivW'(DIV - 1));
  // >= rather than == so that lowering speed mid-count steps on the next base tick.
  assign step      = base_tick && (spd_cnt_q >= speed);

  always_comb begin
    div_cnt_d = div_cnt_q;
    spd_cnt_d = spd_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    if (en) begin
      div_cnt_d = base_tick ? '0 : div_cnt_q + DivW'(1);
      pwm_cnt_d = pwm_cnt_q + 2'd1;
      if (base_tick) begin
        spd_cnt_d = step ? 3'd0 : spd_cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    cur_mode_d  = cur_mode_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    trail_d     = trail_q;
    trail_vld_d = trail_vld_q;
    if (step) begin
      if (mode != cur_mode_q) begin
        cur_mode_d  = mode;
        pos_d       = '0;
        dir_d       = 1'b0;
        trail_vld_d = '0;
      end else begin
        unique case (cur_mode_q)
          ModeBounce: begin
            if (!dir_q) begin
              pos_d = pos_q + PosW'(1);
              if (pos_q == PosW'(N - 2)) dir_d = 1'b1;
            end else begin
              pos_d = pos_q - PosW'(1);
              if (pos_q == PosW'(1)) dir_d = 1'b0;
            end
          end
          ModeRotate: pos_d = (pos_q == PosW'(N - 1)) ? '0 : pos_q + PosW'(1);
          ModeFill:   pos_d = (pos_q == PosW'(N)) ? '0 : pos_q + PosW'(1);
          default:    pos_d = (pos_q == '0) ? PosW'(1) : '0;
        endcase
        if (TrailEn && (cur_mode_q == ModeBounce || cur_mode_q == ModeRotate)) begin
          trail_d[0]     = pos_q;
          trail_vld_d[0] = 1'b1;
          for (int i = 1; i < TrailN; i++) begin
            trail_d[i]     = trail_q[i-1];
            trail_vld_d[i] = trail_vld_q[i-1];
          end
        end
      end
    end
  end

  // led is a pure function of the next pattern state and PWM phase, so it follows
  // the trail dimming every cycle while head/pos still change only on steps.
  always_comb begin
    led_d = '0;
    unique case (cur_mode_d)
      ModeBounce, ModeRotate: begin
        if (TrailEn && (pwm_cnt_d == 2'd0)) begin
          for (int i = 0; i < TrailN; i++) begin
            if (trail_vld_d[i]) led_d = led_d | onehot(trail_d[i]);
          end
        end
        led_d = led_d | onehot(pos_d);
      end
      ModeFill: led_d = fill_mask(pos_d);
      default:  led_d = (pos_d == '0) ? '1 : '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      spd_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      cur_mode_q  <= ModeBounce;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      trail_vld_q <= '0;
      for (int i = 0; i < TrailN; i++) trail_q[i] <= '0;
      led_q       <= N'(1);
      step_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      spd_cnt_q   <= spd_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      cur_mode_q  <= cur_mode_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      trail_vld_q <= trail_vld_d;
      for (int i = 0; i < TrailN; i++) trail_q[i] <= trail_d[i];
      led_q       <= led_d;
      step_q      <= step;
    end
  end

  assign led        = led_q;
  assign pos        = pos_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: step-indexed reference model with
// randomized stimulus; a second instance with TRAIL=0 checks the no-trail build.
module tb_led_pattern_engine;

  localparam int N       = 8;
  localparam int CLK_HZ  = 20;
  localparam int STEP_HZ = 10;
  localparam int TRAIL   = 2;
  localparam int DIV     = CLK_HZ / STEP_HZ;
  localparam int PW      = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] speed = 3'd0;
  logic [N-1:0] led, led_nt;
  logic [PW-1:0] pos, pos_nt;
  logic sp, sp_nt;

  int total = 0;
  int bad = 0;

  // Model: enabled-cycle count, base ticks since last step, steps since mode start.
  int m_en_cnt, m_ticks, m_k;
  logic [1:0] m_mode;
  logic m_pulse;

  led_pattern_engine #(.N(N), .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .TRAIL(TRAIL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
    .led(led), .pos(pos), .step_pulse(sp)
  );

  led_pattern_engine #(.N(N), .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .TRAIL(0)) dut_nt (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
    .led(led_nt), .pos(pos_nt), .step_pulse(sp_nt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic int exp_pos(input logic [1:0] md, input int k);
    int r;
    case (md)
      2'b00: begin
        r = k % (2 * N - 2);
        if (r >= N) r = 2 * N - 2 - r;
      end
      2'b01:   r = k % N;
      2'b10:   r = k % (N + 1);
      default: r = k % 2;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] exp_led(input logic [1:0] md, input int k, input int t,
                                           input int ecnt);
    logic [N-1:0] one, v;
    int p;
    one = N'(1);
    v = '0;
    p = exp_pos(md, k);
    if (md == 2'b10) begin
      for (int i = 0; i < N; i++) if (i < p) v = v | (one << i);
    end else if (md == 2'b11) begin
      v = (p == 0) ? '1 : '0;
    end else begin
      v = one << p;
      if (ecnt % 4 == 0) begin
        for (int j = 1; j <= t; j++) if (k >= j) v = v | (one << exp_pos(md, k - j));
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    m_en_cnt = 0;
    m_ticks  = 0;
    m_k      = 0;
    m_mode   = 2'b00;
    m_pulse  = 1'b0;
  endtask

  task automatic model_update();
    m_pulse = 1'b0;
    if (en) begin
      if (m_en_cnt % DIV == DIV - 1) begin
        if (m_ticks >= int'(speed)) begin
          m_ticks = 0;
          m_pulse = 1'b1;
          if (mode != m_mode) begin
            m_mode = mode;
            m_k = 0;
          end else begin
            m_k++;
          end
        end else begin
          m_ticks++;
        end
      end
      m_en_cnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; speed = 3'd0;
    repeat (2) @(negedge clk);
    total++; if (led !== 8'h01) begin bad++; $display("FAIL reset_led got=%h exp=01", led); end
    total++; if (pos !== '0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    total++; if (sp !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", sp); end
    total++; if (led_nt !== 8'h01) begin bad++; $display("FAIL reset_led_nt got=%h exp=01", led_nt); end
    rst = 1'b0;
    model_reset();
    en = 1'b1;
  endtask

  task automatic test_bounce();
    int last = -1;
    bit seen_top = 1'b0;
    for (int c = 0; c < 60; c++) begin
      cyc();
      total++; if (pos !== PW'(exp_pos(m_mode, m_k))) begin bad++; $display("FAIL bounce_pos c=%0d got=%0d exp=%0d", c, pos, exp_pos(m_mode, m_k)); end
      total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL bounce_led c=%0d got=%h exp=%h", c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
      total++; if (sp !== m_pulse) begin bad++; $display("FAIL bounce_pulse c=%0d got=%b exp=%b", c, sp, m_pulse); end
      if (pos === PW'(N - 1)) seen_top = 1'b1;
      if (sp === 1'b1) begin
        if (last >= 0) begin
          total++; if (c - last != 2) begin bad++; $display("FAIL bounce_gap c=%0d got=%0d exp=2", c, c - last); end
        end
        last = c;
      end
    end
    total++; if (!seen_top) begin bad++; $display("FAIL bounce_top got=0 exp=1"); end
  endtask

  task automatic test_speed();
    int last = -1;
    int np = 0;
    int n;
    speed = 3'd3;
    for (int c = 0; c < 40; c++) begin
      cyc();
      total++; if (pos !== PW'(exp_pos(m_mode, m_k))) begin bad++; $display("FAIL speed_pos c=%0d got=%0d exp=%0d", c, pos, exp_pos(m_mode, m_k)); end
      total++; if (sp !== m_pulse) begin bad++; $display("FAIL speed_pulse c=%0d got=%b exp=%b", c, sp, m_pulse); end
      if (sp === 1'b1) begin
        if (np >= 1) begin
          total++; if (c - last != 8) begin bad++; $display("FAIL speed_gap c=%0d got=%0d exp=8", c, c - last); end
        end
        np++;
        last = c;
      end
    end
    n = 0;
    while (sp !== 1'b1 && n < 20) begin cyc(); n++; end
    total++; if (sp !== 1'b1) begin bad++; $display("FAIL speed_wait got=%b exp=1", sp); end
    repeat (4) cyc();
    speed = 3'd0;
    n = 0;
    do begin cyc(); n++; end while (sp !== 1'b1 && n < 10);
    total++; if (n != 2) begin bad++; $display("FAIL speed_lower got=%0d exp=2", n); end
    for (int c = 0; c < 10; c++) begin
      cyc();
      total++; if (pos !== PW'(exp_pos(m_mode, m_k))) begin bad++; $display("FAIL speed0_pos c=%0d got=%0d exp=%0d", c, pos, exp_pos(m_mode, m_k)); end
      total++; if (sp !== m_pulse) begin bad++; $display("FAIL speed0_pulse c=%0d got=%b exp=%b", c, sp, m_pulse); end
    end
  endtask

  task automatic test_modes();
    logic [1:0] mlist [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [7:0] first [4] = '{8'h01, 8'h00, 8'hFF, 8'h01};
    int runs [4] = '{30, 40, 7, 10};
    int n;
    speed = 3'd0;
    for (int i = 0; i < 4; i++) begin
      mode = mlist[i];
      n = 0;
      do begin cyc(); n++; end while (sp !== 1'b1 && n < 20);
      total++; if (sp !== 1'b1) begin bad++; $display("FAIL mode_wait m=%0d got=%b exp=1", mlist[i], sp); end
      total++; if (led !== first[i]) begin bad++; $display("FAIL mode_first m=%0d got=%h exp=%h", mlist[i], led, first[i]); end
      total++; if (pos !== '0) begin bad++; $display("FAIL mode_pos0 m=%0d got=%0d exp=0", mlist[i], pos); end
      for (int c = 0; c < runs[i]; c++) begin
        cyc();
        total++; if (pos !== PW'(exp_pos(m_mode, m_k))) begin bad++; $display("FAIL mode_pos m=%0d c=%0d got=%0d exp=%0d", m_mode, c, pos, exp_pos(m_mode, m_k)); end
        total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL mode_led m=%0d c=%0d got=%h exp=%h", m_mode, c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
        total++; if (sp !== m_pulse) begin bad++; $display("FAIL mode_pulse m=%0d c=%0d got=%b exp=%b", m_mode, c, sp, m_pulse); end
      end
    end
  endtask

  task automatic test_trail();
    int n;
    int lit = 0;
    speed = 3'd0;
    mode = 2'b01;
    n = 0;
    do begin cyc(); n++; end while (sp !== 1'b1 && n < 20);
    mode = 2'b00;
    n = 0;
    do begin cyc(); n++; end while (sp !== 1'b1 && n < 20);
    speed = 3'd7;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      do begin cyc(); n++; end while (sp !== 1'b1 && n < 40);
    end
    total++; if (pos !== PW'(3)) begin bad++; $display("FAIL trail_pos got=%0d exp=3", pos); end
    for (int c = 0; c < 12; c++) begin
      cyc();
      total++; if (led[3] !== 1'b1) begin bad++; $display("FAIL trail_head c=%0d got=%h", c, led); end
      total++; if ((led & 8'hF7) !== ((m_en_cnt % 4 == 0) ? 8'h06 : 8'h00)) begin bad++; $display("FAIL trail_dim c=%0d got=%h exp=%h", c, led & 8'hF7, (m_en_cnt % 4 == 0) ? 8'h06 : 8'h00); end
      total++; if (led_nt !== 8'h08) begin bad++; $display("FAIL trail_none c=%0d got=%h exp=08", c, led_nt); end
      if ((led & 8'h06) == 8'h06) lit++;
    end
    total++; if (lit != 3) begin bad++; $display("FAIL trail_duty got=%0d exp=3", lit); end
    for (int r = 0; r < 4; r++) begin
      speed = 3'($urandom_range(0, 7));
      mode = 2'($urandom_range(0, 1));
      for (int c = 0; c < 40; c++) begin
        cyc();
        total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL trail_rand_led c=%0d got=%h exp=%h", c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
        total++; if (led_nt !== exp_led(m_mode, m_k, 0, m_en_cnt)) begin bad++; $display("FAIL trail_rand_nt c=%0d got=%h exp=%h", c, led_nt, exp_led(m_mode, m_k, 0, m_en_cnt)); end
      end
    end
  endtask

  task automatic test_en();
    speed = 3'd0;
    mode = 2'($urandom);
    repeat (9) cyc();
    en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      cyc();
      total++; if (sp !== 1'b0) begin bad++; $display("FAIL en_pulse c=%0d got=%b exp=0", c, sp); end
      total++; if (pos !== PW'(exp_pos(m_mode, m_k))) begin bad++; $display("FAIL en_pos c=%0d got=%0d exp=%0d", c, pos, exp_pos(m_mode, m_k)); end
      total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL en_led c=%0d got=%h exp=%h", c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
    end
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      total++; if (sp !== m_pulse) begin bad++; $display("FAIL en_resume_pulse c=%0d got=%b exp=%b", c, sp, m_pulse); end
      total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL en_resume_led c=%0d got=%h exp=%h", c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    mode = 2'b10;
    speed = 3'd0;
    do begin cyc(); n++; end while (!(m_mode == 2'b10 && m_k >= 3) && n < 40);
    @(posedge clk);
    model_update();
    #2 rst = 1'b1;
    #1;
    total++; if (led !== 8'h01) begin bad++; $display("FAIL arst_led got=%h exp=01", led); end
    total++; if (pos !== '0) begin bad++; $display("FAIL arst_pos got=%0d exp=0", pos); end
    total++; if (sp !== 1'b0) begin bad++; $display("FAIL arst_pulse got=%b exp=0", sp); end
    total++; if (led_nt !== 8'h01) begin bad++; $display("FAIL arst_led_nt got=%h exp=01", led_nt); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b00;
    for (int c = 0; c < 20; c++) begin
      cyc();
      total++; if (sp !== m_pulse) begin bad++; $display("FAIL arst_after_pulse c=%0d got=%b exp=%b", c, sp, m_pulse); end
      total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL arst_after_led c=%0d got=%h exp=%h", c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
    end
  endtask

  task automatic test_random();
    logic prev_sp = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) speed = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) != 0);
      cyc();
      total++; if (pos !== PW'(exp_pos(m_mode, m_k))) begin bad++; $display("FAIL rand_pos c=%0d got=%0d exp=%0d", c, pos, exp_pos(m_mode, m_k)); end
      total++; if (led !== exp_led(m_mode, m_k, TRAIL, m_en_cnt)) begin bad++; $display("FAIL rand_led c=%0d got=%h exp=%h", c, led, exp_led(m_mode, m_k, TRAIL, m_en_cnt)); end
      total++; if (led_nt !== exp_led(m_mode, m_k, 0, m_en_cnt)) begin bad++; $display("FAIL rand_led_nt c=%0d got=%h exp=%h", c, led_nt, exp_led(m_mode, m_k, 0, m_en_cnt)); end
      total++; if (sp !== m_pulse) begin bad++; $display("FAIL rand_pulse c=%0d got=%b exp=%b", c, sp, m_pulse); end
      total++; if (prev_sp === 1'b1 && sp === 1'b1) begin bad++; $display("FAIL rand_double_pulse c=%0d got=11 exp=not11", c); end
      prev_sp = sp;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bounce();
    test_speed();
    test_modes();
    test_trail();
    test_en();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
